// File: rtl/twos_decoder_if.sv
// Handshake and data bundle for the bit-serial two's-complement to
// sign-magnitude decoder. The master issues en/A and receives the result.
interface twos_decoder_if;
    logic       en;
    logic [7:0] A;
    logic [7:0] Output;
    logic       ready;
    logic       busy;
    logic       ovf;

    modport master (
        output en,
        output A,
        input  Output,
        input  ready,
        input  busy,
        input  ovf
    );

    modport slave (
        input  en,
        input  A,
        output Output,
        output ready,
        output busy,
        output ovf
    );
endinterface

// File: rtl/twos_decoder.sv
// Bit-serial decoder: 8-bit two's-complement in, 8-bit sign-magnitude out.
// LSB-first, one bit per clock, "copy through the first 1, invert above it".
// The -128 operand cannot be represented and saturates to 8'hFF with ovf set.
module twos_decoder (
    input  logic           clk,
    input  logic           reset,
    twos_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] sr_r;
    logic [7:0] sr_nxt_s;
    logic [7:0] res_r;
    logic [7:0] res_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic       sign_r;
    logic       sign_nxt_s;
    logic       seen_r;
    logic       seen_nxt_s;
    logic [7:0] output_r;
    logic [7:0] output_nxt_s;
    logic       ovf_r;
    logic       ovf_nxt_s;
    logic       ready_r;
    logic       busy_r;
    logic       bit_s;
    logic       res_bit_s;

    // Current serial bit and its converted value (inverted only above the first 1 of a negative operand)
    always_comb begin
        bit_s     = sr_r[0];
        res_bit_s = bit_s ^ (sign_r & seen_r);
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_nxt_s  = state_r;
        sr_nxt_s     = sr_r;
        res_nxt_s    = res_r;
        cnt_nxt_s    = cnt_r;
        sign_nxt_s   = sign_r;
        seen_nxt_s   = seen_r;
        output_nxt_s = output_r;
        ovf_nxt_s    = ovf_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.en) begin
                    sr_nxt_s    = bus.A;
                    sign_nxt_s  = bus.A[7];
                    seen_nxt_s  = 1'b0;
                    cnt_nxt_s   = 3'd0;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                res_nxt_s  = {res_bit_s, res_r[7:1]};
                seen_nxt_s = seen_r | bit_s;
                sr_nxt_s   = {1'b0, sr_r[7:1]};
                cnt_nxt_s  = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    state_nxt_s = DONE;
                    // A set top result bit on a negative operand means magnitude 128
                    if (sign_r & res_nxt_s[7]) begin
                        output_nxt_s = 8'hFF;
                        ovf_nxt_s    = 1'b1;
                    end else begin
                        output_nxt_s = {sign_r, res_nxt_s[6:0]};
                        ovf_nxt_s    = 1'b0;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs; reset aborts any conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            sr_r     <= 8'h00;
            res_r    <= 8'h00;
            cnt_r    <= 3'd0;
            sign_r   <= 1'b0;
            seen_r   <= 1'b0;
            output_r <= 8'h00;
            ovf_r    <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sr_r     <= sr_nxt_s;
            res_r    <= res_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sign_r   <= sign_nxt_s;
            seen_r   <= seen_nxt_s;
            output_r <= output_nxt_s;
            ovf_r    <= ovf_nxt_s;
            ready_r  <= (state_nxt_s == DONE);
            busy_r   <= (state_nxt_s == SHIFT);
        end
    end

    assign bus.Output = output_r;
    assign bus.ovf    = ovf_r;
    assign bus.ready  = ready_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_twos_decoder.sv
// Scoreboard bench for twos_decoder: expected results are pushed when a
// request is issued; a monitor thread pops and compares on each ready pulse.
module tb_twos_decoder;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    twos_decoder_if bus();

    twos_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] sb_q[$];   // {Output, ovf}

    // Reference: interpret A as a signed integer and rebuild sign-magnitude arithmetically
    function automatic logic [8:0] ref_model(input logic [7:0] a);
        int v;
        int mag;
        v = int'($signed(a));
        if (v >= 0) return {a, 1'b0};
        mag = -v;
        if (mag > 127) return {8'hFF, 1'b1};
        return {1'b1, mag[6:0], 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [7:0] a);
        @(negedge clk);
        bus.A  = a;
        bus.en = 1'b1;
        sb_q.push_back(ref_model(a));
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        bus.A  = 8'($urandom);
    endtask

    task automatic wait_ready(output int busy_cyc);
        bit ok;
        ok = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: no ready within 20 cycles");
        end
    endtask

    initial begin
        int bc;
        int cnt;
        int gap;
        int busy_low;
        logic [7:0] dir_vals [5];

        bus.en = 1'b0;
        bus.A  = 8'h00;

        // Monitor thread: compare every ready pulse against the scoreboard
        fork
            forever begin
                logic [8:0] exp;
                @(negedge clk);
                if (bus.ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ready: Output=%0h with empty scoreboard", bus.Output);
                    end else begin
                        exp = sb_q.pop_front();
                        check("output", 32'(bus.Output), 32'(exp[8:1]));
                        check("ovf", 32'(bus.ovf), 32'(exp[0]));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_output", 32'(bus.Output), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        reset = 1'b0;

        // A=12: busy for 8 cycles, single-cycle ready
        start(8'd12);
        wait_ready(bc);
        check("busy_cycles", 32'(bc), 32'd8);
        check("busy_in_done", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("ready_one_cycle", 32'(bus.ready), 32'h0);
        check("output_held_idle", 32'(bus.Output), 32'h0C);

        // Directed boundary values, including -128 followed by zero
        dir_vals = '{8'hF4, 8'hFF, 8'h81, 8'h80, 8'h00};
        foreach (dir_vals[i]) begin
            start(dir_vals[i]);
            wait_ready(bc);
        end

        // en during SHIFT is ignored
        start(8'hF4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.A  = 8'h05;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) cnt++;
        end
        check("ignored_en_ready_count", 32'(cnt), 32'd1);
        check("ignored_en_idle_busy", 32'(bus.busy), 32'h0);
        check("ignored_en_output", 32'(bus.Output), 32'h8C);

        // Back-to-back with en held high
        @(negedge clk);
        bus.A  = 8'h0C;
        bus.en = 1'b1;
        sb_q.push_back(ref_model(8'h0C));
        @(posedge clk);
        #1;
        bus.A = 8'hF4;
        sb_q.push_back(ref_model(8'hF4));
        wait_ready(bc);
        check("b2b_busy_first", 32'(bc), 32'd8);
        check("b2b_busy_done", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        bus.A  = 8'($urandom);
        gap = 0;
        busy_low = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                gap = i;
                break;
            end
            if (bus.busy !== 1'b1) busy_low++;
        end
        check("b2b_ready_gap", 32'(gap), 32'd9);
        check("b2b_busy_low", 32'(busy_low), 32'd0);

        // Asynchronous reset on the 4th SHIFT cycle aborts without ready
        start(8'hF4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_output", 32'(bus.Output), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_ready", 32'(bus.ready), 32'h0);
        check("arst_ovf", 32'(bus.ovf), 32'h0);
        void'(sb_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) cnt++;
        end
        check("arst_no_ready", 32'(cnt), 32'd0);
        start(8'hF4);
        wait_ready(bc);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            start(8'($urandom));
            wait_ready(bc);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/twos_decoder.md
# twos_decoder

Bit-serial decoder that converts an 8-bit two's-complement operand back to 8-bit sign-magnitude form (bit 7 = sign, bits 6:0 = magnitude). It is the return path for the `twos_compliment` encoder: encoder results feed this block to be displayed or stored in sign-magnitude. It uses the same `en`/`ready` start/done handshake as the encoder. Conversion is LSB-first, one bit per clock, using the "copy through first 1, invert above it" rule.

## Interface
Parameters:
- none. Width is fixed at 8 bits.

Ports:
- `clk`  in  1  Single system clock. All state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `en`  in  1  Start request. Sampled only in IDLE or DONE.
- `A`  in  8  Two's-complement operand. Latched on the accepting edge.
- `Output`  out  8  Sign-magnitude result `{sign, mag[6:0]}`. Holds its value until the next completion.
- `ready`  out  1  One-cycle done pulse. `Output` is valid while it is high.
- `busy`  out  1  High while serial conversion is in progress.
- `ovf`  out  1  Magnitude-overflow flag for the result in `Output`.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - `en`=1 → latch `A` into shift register `sr`.
  - `sign`←`A[7]`, `seen`←0, `cnt`←0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT processes one bit per cycle, with `b = sr[0]`:
  - Result bit = `b ^ (sign & seen)`, shifted into `res` from the MSB side.
  - `seen` ← `seen | b`.
  - `sr` shifts right and `cnt` increments.
  - When `cnt`==7 this cycle, go to DONE.
- Entering DONE (same edge as the 8th bit):
  - `Output` ← `{sign, res[6:0]}`, `ready` ← 1, `ovf` ← (`sign` & `res[7]`).
- `ovf` case: only when A = 8'h80 (-128); the magnitude 128 does not fit in 7 bits.
  - `Output` is then forced to 8'hFF (saturated to -127) and `ovf`=1.
- DONE lasts exactly one cycle.
  - `en`=1 → accept a new `A` exactly as IDLE does, go to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- `en` in SHIFT is ignored. The request is not queued.
- Positive operands pass through unchanged: `sign`=0, so no bits are inverted.
- Zero → 8'h00, `ovf`=0. Negative zero is never produced.
- `busy` = (state==SHIFT). `ready` = (state==DONE).

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - `Output`=8'h00, `ready`=0, `busy`=0, `ovf`=0.
  - `sr`, `res`, `cnt`, `sign`, `seen` all =0.
- Let E0 be the edge that samples `en`=1 in IDLE.
  - `busy` rises after E0.
  - Bits 0..7 are processed on E1..E8.
  - `Output`, `ovf` and `ready` update on E8. `busy` falls on E8.
  - `ready` is high from E8 to E9.
- Latency is 8 clocks from the accepting edge to `ready`.
- Throughput with `en` held high is one result per 9 clocks, since DONE restarts immediately.
- `A` need only be stable at the accepting edge. Later changes do not affect the conversion in progress.
- Reset asserted mid-SHIFT aborts the conversion:
  - No `ready` pulse is produced.
  - `Output` goes to 8'h00.
- Reset has priority over every other event. Reset and `en` in the same cycle → `en` is lost.
- `ovf` and `Output` change only on completion or reset; they are held through IDLE and SHIFT.

## Test plan
- Reset, then A=8'd12 with `en` pulsed 1 cycle:
  - `busy` is high for 8 cycles.
  - On the 8th edge: `ready`=1 for one cycle, `Output`=8'h0C, `ovf`=0.
- A=8'hF4 (-12) → `Output`=8'h8C, `ovf`=0.
  - A=8'hFF (-1) → 8'h81.
  - A=8'h81 (-127) → 8'hFF, `ovf`=0.
- A=8'h80 → `Output`=8'hFF, `ovf`=1.
  - Next conversion of A=8'h00 → `Output`=8'h00 and `ovf` cleared to 0.
- A=8'hF4 accepted, then `en`=1 with A=8'h05 on the 3rd SHIFT cycle:
  - The second request is ignored.
  - Exactly one `ready` pulse, `Output`=8'h8C.
  - State returns to IDLE.
- `en` held high with A changing each accept (8'h0C then 8'hF4):
  - `ready` pulses 9 cycles apart.
  - `Output` goes 8'h0C, then 8'h8C.
  - `busy` is low only during the DONE cycle.
- Reset asserted asynchronously (between edges) on the 4th SHIFT cycle of A=8'hF4:
  - All outputs go to 0 immediately, with no `ready`.
  - After reset release, a fresh A=8'hF4 conversion yields 8'h8C.
